// File: rtl/lpc_pkg.sv
// ---------------------------------------------------------------------------
// lpc_pkg
// Shared LPC definitions used by the LPC host (initiator) and by the passive
// LPC cycle decoder at the other end of the bus.
//   - lpc_state_e : host bus-cycle state encoding
//   - CYC_*       : CYCTYPE+DIR nibble values for the supported cycles
//   - SYNC_*      : SYNC field codes returned by a peripheral
//   - STATUS_*    : user-side response status codes
//   - cyctype_supported() : true for single-byte IO/memory read/write
// ---------------------------------------------------------------------------
package lpc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_CYCDIR,
        ST_ADDR,
        ST_WDATA,
        ST_TAR1,
        ST_TAR2,
        ST_SYNC,
        ST_RDATA,
        ST_TAR_END1,
        ST_TAR_END2,
        ST_RSP,
        ST_ABORT,
        ST_ABORT_END
    } lpc_state_e;

    localparam logic [3:0] CYC_IO_RD  = 4'b0000;
    localparam logic [3:0] CYC_IO_WR  = 4'b0010;
    localparam logic [3:0] CYC_MEM_RD = 4'b0100;
    localparam logic [3:0] CYC_MEM_WR = 4'b0110;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;
    localparam logic [3:0] SYNC_NONE       = 4'b1111;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_SYNC_ERR = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;
    localparam logic [1:0] STATUS_UNSUP    = 2'b11;

    // Only the four single-byte IO/memory cycles are generated by the host;
    // DMA, bus-master and reserved encodings are rejected without bus activity.
    function automatic logic cyctype_supported(input logic [3:0] cyc);
        return (cyc == CYC_IO_RD) || (cyc == CYC_IO_WR) ||
               (cyc == CYC_MEM_RD) || (cyc == CYC_MEM_WR);
    endfunction

endpackage

// File: rtl/lpc_sync_mon.sv
// ---------------------------------------------------------------------------
// lpc_sync_mon
// Watches the SYNC field while the host is in its SYNC phase and classifies
// each sampled nibble. Keeps a short-wait counter (SYNC_TIMEOUT, also used
// for no-response 1111 and unknown codes) and a long-wait counter
// (LONG_WAIT_MAX). A counter restarts whenever the SYNC code changes.
// Ports:
//   lpc_clock_i  : bus clock, rising edge
//   lpc_reset_ni : asynchronous active-low reset
//   en_i         : high while the host is in the SYNC phase
//   ad_i         : sampled LPC AD nibble
//   ready_o      : SYNC=0000 this cycle
//   error_o      : SYNC=1010 this cycle
//   timeout_o    : a wait counter reaches its limit on this sample
// ---------------------------------------------------------------------------
module lpc_sync_mon
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT  = 8,
    parameter int unsigned LONG_WAIT_MAX = 255
) (
    input  logic       lpc_clock_i,
    input  logic       lpc_reset_ni,
    input  logic       en_i,
    input  logic [3:0] ad_i,
    output logic       ready_o,
    output logic       error_o,
    output logic       timeout_o
);

    localparam int SW = $clog2(SYNC_TIMEOUT + 1);
    localparam int LW = $clog2(LONG_WAIT_MAX + 1);
    localparam logic [SW-1:0] SHORT_LIMIT = SW'(SYNC_TIMEOUT);
    localparam logic [LW-1:0] LONG_LIMIT  = LW'(LONG_WAIT_MAX);

    logic [3:0]    prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic [SW-1:0] short_q, short_d;
    logic [LW-1:0] long_q, long_d;
    logic          same_code;

    // Classify the current nibble and advance whichever wait counter applies.
    // Only one counter can be non-zero at a time because any code change
    // restarts counting from one; outside SYNC everything is cleared.
    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        short_d    = short_q;
        long_d     = long_q;
        ready_o    = 1'b0;
        error_o    = 1'b0;
        timeout_o  = 1'b0;
        same_code  = prev_vld_q && (ad_i == prev_q);

        if (!en_i) begin
            prev_vld_d = 1'b0;
            short_d    = '0;
            long_d     = '0;
        end else begin
            prev_d     = ad_i;
            prev_vld_d = 1'b1;
            short_d    = '0;
            long_d     = '0;
            if (ad_i == SYNC_READY) begin
                ready_o = 1'b1;
            end else if (ad_i == SYNC_ERROR) begin
                error_o = 1'b1;
            end else if (ad_i == SYNC_LONG_WAIT) begin
                long_d    = same_code ? long_q + LW'(1) : LW'(1);
                timeout_o = (long_d == LONG_LIMIT);
            end else begin
                short_d   = same_code ? short_q + SW'(1) : SW'(1);
                timeout_o = (short_d == SHORT_LIMIT);
            end
        end
    end

    // Counter and last-code registers.
    always_ff @(posedge lpc_clock_i or negedge lpc_reset_ni) begin
        if (!lpc_reset_ni) begin
            prev_q     <= SYNC_NONE;
            prev_vld_q <= 1'b0;
            short_q    <= '0;
            long_q     <= '0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            short_q    <= short_d;
            long_q     <= long_d;
        end
    end

endmodule

// File: rtl/lpc_host.sv
// ---------------------------------------------------------------------------
// lpc_host
// LPC 1.1 host: issues single-byte IO and memory read/write cycles on
// lpc_frame / lpc_ad_* from a valid/ready request, returns a one-cycle
// response pulse with read data and status.
// Optional feature macro: LPC_ABORT_EN -- on a SYNC timeout, abort the cycle
// by holding frame low with AD=1111 for 4 clocks, then one recovery clock.
// Ports:
//   lpc_clock, lpc_reset (async, active low)
//   req_valid/req_ready, req_cyctype_dir[3:0], req_addr[31:0], req_data[7:0]
//   rsp_valid (1-cycle pulse), rsp_data[7:0], rsp_status[1:0]
//   lpc_frame (active low), lpc_ad_out[3:0], lpc_ad_oe, lpc_ad_in[3:0]
// ---------------------------------------------------------------------------
module lpc_host
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT  = 8,
    parameter int unsigned LONG_WAIT_MAX = 255
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [1:0]  rsp_status,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);

    lpc_state_e  state_q, state_d;
    logic [3:0]  nib_q, nib_d;
    logic [3:0]  cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;

    logic sync_en;
    logic sync_ready;
    logic sync_error;
    logic sync_timeout;

    assign sync_en = (state_q == ST_SYNC);

    lpc_sync_mon #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .LONG_WAIT_MAX(LONG_WAIT_MAX)
    ) u_sync_mon (
        .lpc_clock_i (lpc_clock),
        .lpc_reset_ni(lpc_reset),
        .en_i        (sync_en),
        .ad_i        (lpc_ad_in),
        .ready_o     (sync_ready),
        .error_o     (sync_error),
        .timeout_o   (sync_timeout)
    );

    // Next-state logic for the bus cycle. nib_q is a shared down-counter:
    // address nibbles (7..0 or 3..0, MSB first), data halves (1 = low
    // nibble, 0 = high nibble) and the abort hold length.
    // rdata_q is cleared on accept so writes and failed reads report 0.
    always_comb begin
        state_d  = state_q;
        nib_d    = nib_q;
        cyc_d    = cyc_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        status_d = status_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cyc_d   = req_cyctype_dir;
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    rdata_d = '0;
                    if (cyctype_supported(req_cyctype_dir)) begin
                        status_d = STATUS_OK;
                        state_d  = ST_START;
                    end else begin
                        status_d = STATUS_UNSUP;
                        state_d  = ST_RSP;
                    end
                end
            end
            ST_START: state_d = ST_CYCDIR;
            ST_CYCDIR: begin
                state_d = ST_ADDR;
                nib_d   = cyc_q[2] ? 4'd7 : 4'd3;
            end
            ST_ADDR: begin
                if (nib_q == 4'd0) begin
                    if (cyc_q[1]) begin
                        state_d = ST_WDATA;
                        nib_d   = 4'd1;
                    end else begin
                        state_d = ST_TAR1;
                    end
                end else begin
                    nib_d = nib_q - 4'd1;
                end
            end
            ST_WDATA: begin
                if (nib_q == 4'd0) begin
                    state_d = ST_TAR1;
                end else begin
                    nib_d = 4'd0;
                end
            end
            ST_TAR1: state_d = ST_TAR2;
            ST_TAR2: state_d = ST_SYNC;
            ST_SYNC: begin
                if (sync_ready) begin
                    if (cyc_q[1]) begin
                        state_d = ST_TAR_END1;
                    end else begin
                        state_d = ST_RDATA;
                        nib_d   = 4'd1;
                    end
                end else if (sync_error) begin
                    status_d = STATUS_SYNC_ERR;
                    state_d  = ST_TAR_END1;
                end else if (sync_timeout) begin
                    status_d = STATUS_TIMEOUT;
`ifdef LPC_ABORT_EN
                    state_d  = ST_ABORT;
                    nib_d    = 4'd3;
`else
                    state_d  = ST_TAR_END1;
`endif
                end
            end
            ST_RDATA: begin
                if (nib_q[0]) begin
                    rdata_d[3:0] = lpc_ad_in;
                    nib_d        = 4'd0;
                end else begin
                    rdata_d[7:4] = lpc_ad_in;
                    state_d      = ST_TAR_END1;
                end
            end
            ST_TAR_END1: state_d = ST_TAR_END2;
            ST_TAR_END2: state_d = ST_RSP;
            ST_RSP:      state_d = ST_IDLE;
`ifdef LPC_ABORT_EN
            ST_ABORT: begin
                if (nib_q == 4'd0) begin
                    state_d = ST_ABORT_END;
                end else begin
                    nib_d = nib_q - 4'd1;
                end
            end
            ST_ABORT_END: state_d = ST_RSP;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pins are a pure decode of the registered state so that an async
    // reset returns them to idle values immediately. AD is only driven
    // from START through TAR1 (and during an abort).
    always_comb begin
        lpc_frame  = 1'b1;
        lpc_ad_oe  = 1'b0;
        lpc_ad_out = SYNC_NONE;
        case (state_q)
            ST_START: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = 4'b0000;
            end
            ST_CYCDIR: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = cyc_q;
            end
            ST_ADDR: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = addr_q[{nib_q[2:0], 2'b00} +: 4];
            end
            ST_WDATA: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = nib_q[0] ? wdata_q[3:0] : wdata_q[7:4];
            end
            ST_TAR1: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = SYNC_NONE;
            end
`ifdef LPC_ABORT_EN
            ST_ABORT: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = SYNC_NONE;
            end
`endif
            default: begin
                lpc_frame  = 1'b1;
                lpc_ad_oe  = 1'b0;
                lpc_ad_out = SYNC_NONE;
            end
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RSP);
    assign rsp_data   = rdata_q;
    assign rsp_status = status_q;

    // State and captured-request registers.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_q  <= ST_IDLE;
            nib_q    <= '0;
            cyc_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            status_q <= STATUS_OK;
        end else begin
            state_q  <= state_d;
            nib_q    <= nib_d;
            cyc_q    <= cyc_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC 1.1 host (initiator): drives single-byte I/O and memory read/write cycles onto lpc_ad/lpc_frame.
- Opposite end of the bus from the passive LPC cycle decoder.
- Used by the sniffer bench and board bring-up to generate real traffic toward peripherals.
- Request/response handshake on the user side; tri-state AD split into out/oe/in.

Parameters:
- SYNC_TIMEOUT, 8: max consecutive lpc_clock cycles with SYNC=1111 (no response) before timeout.
- LONG_WAIT_MAX, 255: max consecutive long-wait (0110) SYNC cycles before timeout.

Ports:
- lpc_clock  in  1  bus clock; all logic on rising edge.
- lpc_reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; transfer when req_valid && req_ready.
- req_cyctype_dir  in  4  LPC CYCTYPE+DIR nibble: 0000 IO rd, 0010 IO wr, 0100 mem rd, 0110 mem wr.
- req_addr  in  32  address; IO uses [15:0].
- req_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse at cycle end.
- rsp_data  out  8  read data (0 for writes/errors).
- rsp_status  out  2  00 ok, 01 sync error (1010), 10 timeout, 11 unsupported cyctype.
- lpc_frame  out  1  active-low frame.
- lpc_ad_out  out  4  AD drive value.
- lpc_ad_oe  out  1  AD output enable.
- lpc_ad_in  in  4  sampled AD.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_status=00, lpc_frame=1, lpc_ad_out=1111, lpc_ad_oe=0, state IDLE.
- Reset is async; mid-cycle assertion abandons the cycle with no rsp_valid.
- Request capture:
  - On accept, latch cyctype/addr/data.
  - cyctype[3:2] not 00/01, or cyctype[0]=1: no bus activity. rsp_valid next cycle with status 11.
- States, one lpc_clock each unless noted:
  - START: frame=0, AD=0000, oe=1.
  - CYCDIR: frame=1, AD=cyctype.
  - ADDR: 4 nibbles (IO, addr[15:0]) or 8 nibbles (mem, addr[31:0]), MSB nibble first; 4-bit down-counter.
  - WDATA (writes only): data[3:0] then data[7:4].
  - TAR1: AD=1111, oe=1.
  - TAR2: oe=0.
  - SYNC: sample lpc_ad_in each cycle.
    - 0000 ready: reads go to RDATA; writes go to TAR_END.
    - 0101 short wait: stay; count against SYNC_TIMEOUT.
    - 0110 long wait: stay; count against LONG_WAIT_MAX.
    - 1010 error: go to TAR_END, status 01.
    - 1111 or other value: count against SYNC_TIMEOUT.
    - Wait counter resets on any change of SYNC code.
  - RDATA: sample low nibble, then high nibble.
  - TAR_END1/TAR_END2: oe=0; peripheral drives 1111 then floats.
- rsp_valid pulses in the cycle after TAR_END2, then IDLE. Earliest next START follows that cycle, so req_ready is low for the whole bus cycle.
- Timeout when the counter reaches its limit: status 10. Without abort, go to TAR_END.
- Latency, IO write with zero wait: START(1) + CYCDIR(1) + ADDR(4) + WDATA(2) + TAR(2) + SYNC(1) + TAR_END(2) = 13 clocks from accept to rsp_valid.
- Latency, IO read with zero wait: 13 clocks (WDATA is replaced by RDATA(2)).
- oe is never high in TAR2, SYNC, RDATA, or TAR_END.

Optional Feature:
- LPC_ABORT_EN defined:
  - On timeout, drive lpc_frame=0, AD=1111, oe=1 for 4 clocks.
  - Then 1 clock frame=1, oe=0; rsp_valid with status 10.
- Undefined: timeout goes straight to TAR_END; abort logic absent.

Decomposition:
- Package lpc_pkg holds:
  - State enum.
  - CYCTYPE constants (IO_RD, IO_WR, MEM_RD, MEM_WR).
  - SYNC codes (READY 0000, SHORT_WAIT 0101, LONG_WAIT 0110, ERROR 1010, NONE 1111).
  - rsp_status constants.
- Shared with the decoder.
- One sub-module: lpc_sync_mon. It takes lpc_ad_in and the enable, and outputs ready/error/timeout with both wait counters.

Test Plan:
- IO write addr=0x0080, data=0xA5, peripheral SYNC 0000 immediately:
  - AD sequence 0000, 0010, 0, 0, 8, 0, 5, A, 1111, Z.
  - rsp_valid 13 clocks after accept, status 00.
- Mem read addr=0xFFFF_FFF0, two short waits then READY, data nibbles 3 then C: rsp_data=0xC3, status 00.
- IO read, SYNC stuck at 1111: after 8 clocks, status 10, rsp_data=0.
  - With LPC_ABORT_EN, frame low exactly 4 clocks with AD=1111.
- IO write, SYNC=1010: status 01; no RDATA phase; oe=0 through TAR_END.
- req_cyctype_dir=1000 (DMA): lpc_frame stays 1, rsp_valid next cycle with status 11.
- lpc_reset asserted during ADDR: outputs return to reset values immediately; no rsp_valid; next request runs normally.
